// File: rtl/run_det_sched_pkg.sv
// Shared defaults for the run-length detection scheduler.
package run_det_pkg;

   localparam int unsigned N_CH       = 4;
   localparam int unsigned CNT_W      = 3;
   localparam int unsigned DEF_THRESH = 3;
   localparam int unsigned CH_W       = $clog2(N_CH);
   localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

endpackage

// File: rtl/run_det_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter
   import run_det_pkg::*;
#(
   parameter int unsigned N  = N_CH,
   parameter int unsigned PW = CH_W
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      int unsigned j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr_i) + k) % N;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/run_det_sched.sv
// Time-shared consecutive-1s detector: one engine, per-channel run counter
// and detect table, round-robin scheduled.
module run_det_sched #(
   parameter int unsigned  N_CH       = run_det_pkg::N_CH,
   parameter int unsigned  CNT_W      = run_det_pkg::CNT_W,
   parameter int unsigned  DEF_THRESH = run_det_pkg::DEF_THRESH,
   localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  req,
   input  logic [N_CH-1:0]  bit_in,
   output logic [N_CH-1:0]  gnt,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_thresh,
   output logic [N_CH-1:0]  detect,
   output logic             hit_v,
   output logic [CH_W-1:0]  hit_ch,
   output logic [CNT_W-1:0] thresh_q
);

   import run_det_pkg::*;

   localparam logic [CNT_W-1:0] SAT        = '1;
   localparam logic [CNT_W-1:0] THRESH_RST = CNT_W'(DEF_THRESH);

   logic [N_CH-1:0]  req_ok;
   logic [CH_W-1:0]  ptr_q, ptr_d;
   logic [CH_W-1:0]  g;
   logic             gnt_any;

   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [N_CH-1:0]  detect_q, detect_d;
   logic             hit_v_q, hit_v_d;
   logic [CH_W-1:0]  hit_ch_q, hit_ch_d;
   logic [CNT_W-1:0] thresh_d;
   logic [CNT_W-1:0] cnt_new;
   logic             det_new;

   // Grant is masked while reset is held so no bit is consumed in that cycle.
   assign req_ok = rst ? req : '0;

   rr_arbiter #(
      .N  (N_CH),
      .PW (CH_W)
   ) u_arb (
      .req_i (req_ok),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (g),
      .any_o (gnt_any)
   );

   always_comb begin
      cnt_d    = cnt_q;
      detect_d = detect_q;
      ptr_d    = ptr_q;
      hit_v_d  = 1'b0;
      hit_ch_d = hit_ch_q;
      cnt_new  = '0;
      det_new  = 1'b0;
      if (gnt_any) begin
         if (bit_in[g])
            cnt_new = (cnt_q[g] == SAT) ? SAT : cnt_q[g] + CNT_W'(1);
         det_new     = (cnt_new >= thresh_q);
         cnt_d[g]    = cnt_new;
         detect_d[g] = det_new;
         ptr_d       = (g == CH_W'(N_CH - 1)) ? '0 : g + CH_W'(1);
         if (det_new && !detect_q[g]) begin
            hit_v_d  = 1'b1;
            hit_ch_d = g;
         end
      end
   end

   // A zero threshold would make every idle channel detect; clamp to 1.
   always_comb begin
      thresh_d = thresh_q;
      if (cfg_we)
         thresh_d = (cfg_thresh == '0) ? CNT_W'(1) : cfg_thresh;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q    <= '0;
         detect_q <= '0;
         hit_v_q  <= 1'b0;
         hit_ch_q <= '0;
         thresh_q <= THRESH_RST;
         for (int unsigned i = 0; i < N_CH; i++)
            cnt_q[i] <= '0;
      end else begin
         ptr_q    <= ptr_d;
         detect_q <= detect_d;
         hit_v_q  <= hit_v_d;
         hit_ch_q <= hit_ch_d;
         thresh_q <= thresh_d;
         for (int unsigned i = 0; i < N_CH; i++)
            cnt_q[i] <= cnt_d[i];
      end
   end

   assign detect = detect_q;
   assign hit_v  = hit_v_q;
   assign hit_ch = hit_ch_q;

endmodule

// File: tb/tb_run_det_sched.sv
// Directed-vector bench for run_det_sched with default parameters.
module tb_run_det_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] bit_in;
   logic [3:0] gnt;
   logic       cfg_we;
   logic [2:0] cfg_thresh;
   logic [3:0] detect;
   logic       hit_v;
   logic [1:0] hit_ch;
   logic [2:0] thresh_q;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned nh;

   run_det_sched dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .bit_in     (bit_in),
      .gnt        (gnt),
      .cfg_we     (cfg_we),
      .cfg_thresh (cfg_thresh),
      .detect     (detect),
      .hit_v      (hit_v),
      .hit_ch     (hit_ch),
      .thresh_q   (thresh_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; req = 4'b1111; bit_in = '0; cfg_we = 1'b0; cfg_thresh = '0;
      tick(); tick();
      chk("rst_gnt",   32'(gnt),      32'h0);
      chk("rst_det",   32'(detect),   32'h0);
      chk("rst_hit",   32'(hit_v),    32'h0);
      chk("rst_hitch", 32'(hit_ch),   32'h0);
      chk("rst_thr",   32'(thresh_q), 32'd3);

      rst = 1'b1; #1;
      chk("rel_gnt", 32'(gnt), 32'b0001);

      for (int i = 0; i < 4; i++) begin
         chk("rr4_gnt", 32'(gnt), 32'(1 << i));
         tick();
      end
      req = 4'b0101; #1;
      chk("rr5_gnt0", 32'(gnt), 32'b0001); tick();
      chk("rr5_gnt1", 32'(gnt), 32'b0100); tick();
      chk("rr5_gnt2", 32'(gnt), 32'b0001); tick();
      chk("rr_ptr", 32'(dut.ptr_q), 32'd1);
      chk("rr_det", 32'(detect), 32'h0);

      req = 4'b0001; bit_in = 4'b0001;
      tick(); tick();
      chk("run2_det", 32'(detect), 32'h0);
      tick();
      chk("run3_det",   32'(detect), 32'b0001);
      chk("run3_hit",   32'(hit_v),  32'd1);
      chk("run3_hitch", 32'(hit_ch), 32'd0);
      bit_in = 4'b0000; tick();
      chk("brk_det", 32'(detect),       32'h0);
      chk("brk_hit", 32'(hit_v),        32'd0);
      chk("brk_cnt", 32'(dut.cnt_q[0]), 32'd0);

      req = 4'b0100; bit_in = 4'b0100; nh = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (hit_v) nh++;
      end
      chk("sat_cnt",   32'(dut.cnt_q[2]), 32'd7);
      chk("sat_det",   32'(detect),       32'b0100);
      chk("sat_nhit",  nh,                32'd1);
      chk("sat_hitch", 32'(hit_ch),       32'd2);
      bit_in = 4'b0000; tick();
      chk("sat_clr", 32'(detect), 32'h0);

      req = 4'b0000; cfg_we = 1'b1; cfg_thresh = 3'd0; tick(); cfg_we = 1'b0;
      chk("thr0_clamp", 32'(thresh_q), 32'd1);
      req = 4'b0010; bit_in = 4'b0010; tick();
      chk("thr1_det",   32'(detect), 32'b0010);
      chk("thr1_hitch", 32'(hit_ch), 32'd1);
      bit_in = 4'b0000; tick();
      req = 4'b0000; cfg_we = 1'b1; cfg_thresh = 3'd3; tick(); cfg_we = 1'b0;
      chk("thr3_load", 32'(thresh_q), 32'd3);

      req = 4'b0010; bit_in = 4'b0010;
      tick(); tick();
      chk("cfg_pre_det", 32'(detect), 32'h0);
      cfg_we = 1'b1; cfg_thresh = 3'd5; tick(); cfg_we = 1'b0;
      chk("cfg_old_thr", 32'(detect),   32'b0010);
      chk("cfg_hit",     32'(hit_v),    32'd1);
      chk("cfg_thr5",    32'(thresh_q), 32'd5);
      tick();
      chk("cfg_new_thr", 32'(detect), 32'h0);
      bit_in = 4'b0000; tick();
      req = 4'b0000; cfg_we = 1'b1; cfg_thresh = 3'd3; tick(); cfg_we = 1'b0;

      req = 4'b1000; bit_in = 4'b1000; tick(); tick();
      chk("ar_cnt3", 32'(dut.cnt_q[3]), 32'd2);
      req = 4'b0001; bit_in = 4'b0001; tick(); tick(); tick();
      chk("ar_det0", 32'(detect),     32'b0001);
      chk("ar_ptr",  32'(dut.ptr_q),  32'd1);

      req = 4'b1111; bit_in = 4'b1111; #2;
      rst = 1'b0; #1;
      chk("ar_det",  32'(detect),       32'h0);
      chk("ar_gnt",  32'(gnt),          32'h0);
      chk("ar_ptr0", 32'(dut.ptr_q),    32'd0);
      chk("ar_hit",  32'(hit_v),        32'd0);
      chk("ar_cnt0", 32'(dut.cnt_q[3]), 32'd0);
      chk("ar_thr",  32'(thresh_q),     32'd3);
      tick();
      rst = 1'b1; req = 4'b1000; bit_in = 4'b1000; #1;
      chk("ar_rel_gnt", 32'(gnt), 32'b1000);
      tick(); tick();
      chk("ar_run2_det", 32'(detect), 32'h0);
      tick();
      chk("ar_run3_det",   32'(detect), 32'b1000);
      chk("ar_run3_hit",   32'(hit_v),  32'd1);
      chk("ar_run3_hitch", 32'(hit_ch), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
